// File: rtl/extended_word_unpacker_pkg.sv
// Shared definitions for the extended word unpacker: default signature,
// resync FSM state encoding and the buffered payload/address entry.
package extended_word_unpacker_pkg;

  localparam int unsigned SIG_WIDTH          = 32;
  localparam logic [31:0] DEFAULT_SIGNATURE  = 32'h12345678;
  localparam int unsigned DEF_DATA_WIDTH     = 8;
  localparam int unsigned DEF_ADDR_WIDTH     = 16;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DROP = 1'b1
  } unpack_state_e;

  // One FIFO entry at the default widths: payload above address.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_ADDR_WIDTH-1:0] addr;
  } unpack_entry_t;

endpackage

// File: rtl/extended_word_unpacker_sync_fifo.sv
// Registered synchronous FIFO, no fall-through. Full/empty derive from the
// occupancy count; pushes while full and pops while empty are ignored.
// Ports: clk, reset (sync, active-high), push/wdata in, pop in,
//        full/empty/level status, rdata = head entry.
module unpacker_sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   level,
  output logic [WIDTH-1:0] rdata
);

  localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   LVL_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             push_eff;
  logic             pop_eff;

  assign full     = (level_q == LVL_FULL);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign rdata    = mem_q[rd_ptr_q];
  assign push_eff = push & ~full;
  assign pop_eff  = pop & ~empty;

  // Pointer and occupancy update; pointers wrap naturally (power-of-two depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_eff) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_eff, pop_eff})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/extended_word_unpacker.sv
// Extended word unpacker: checks the signature and duplicated address of each
// incoming word, buffers good payload/address pairs in a FIFO and counts bad
// words. After a signature error a resync state drops traffic until a word
// with a valid signature arrives.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_data/in_addr
//        input stream; out_valid/out_ready/out_data/out_addr output stream;
//        level occupancy; sig_err_cnt/addr_err_cnt saturating counters;
//        resync (DROP state); clear_err zeroes the counters.
module extended_word_unpacker
  import extended_word_unpacker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] SIGNATURE  = DEFAULT_SIGNATURE,
  parameter int unsigned ERR_WIDTH  = 8,
  localparam int unsigned EXT_WIDTH       = DATA_WIDTH + SIG_WIDTH,
  localparam int unsigned FULL_ADDR_WIDTH = 2 * ADDR_WIDTH,
  localparam int unsigned PTR_W           = $clog2(FIFO_DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXT_WIDTH-1:0]       in_data,
  input  logic [FULL_ADDR_WIDTH-1:0] in_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [ADDR_WIDTH-1:0]      out_addr,
  output logic [PTR_W:0]             level,
  output logic [ERR_WIDTH-1:0]       sig_err_cnt,
  output logic [ERR_WIDTH-1:0]       addr_err_cnt,
  output logic                       resync,
  input  logic                       clear_err
);

  localparam int unsigned         ENTRY_W = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [ERR_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [ERR_WIDTH-1:0] CNT_ONE = ERR_WIDTH'(1);

  unpack_state_e        state_q, state_d;
  logic [ERR_WIDTH-1:0] sig_err_cnt_q, sig_err_cnt_d;
  logic [ERR_WIDTH-1:0] addr_err_cnt_q, addr_err_cnt_d;

  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic               push;
  logic               sig_inc;
  logic               addr_inc;
  logic               accept;
  logic               sig_ok;
  logic               addr_ok;

  assign in_ready     = ~fifo_full;
  assign out_valid    = ~fifo_empty;
  assign out_data     = fifo_head[ENTRY_W-1:ADDR_WIDTH];
  assign out_addr     = fifo_head[ADDR_WIDTH-1:0];
  assign sig_err_cnt  = sig_err_cnt_q;
  assign addr_err_cnt = addr_err_cnt_q;
  assign resync       = (state_q == ST_DROP);

  assign accept     = in_valid & ~fifo_full;
  assign sig_ok     = (in_data[SIG_WIDTH-1:0] == SIGNATURE);
  assign addr_ok    = (in_addr[FULL_ADDR_WIDTH-1:ADDR_WIDTH] == in_addr[ADDR_WIDTH-1:0]);
  assign fifo_wdata = {in_data[EXT_WIDTH-1:SIG_WIDTH], in_addr[ADDR_WIDTH-1:0]};

  // Resync FSM and word classification. A good signature always returns to
  // RUN and the same word is then judged on its address; only the first bad
  // signature of a run is counted.
  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    sig_inc  = 1'b0;
    addr_inc = 1'b0;
    if (accept) begin
      if (!sig_ok) begin
        state_d = ST_DROP;
        sig_inc = (state_q == ST_RUN);
      end else begin
        state_d = ST_RUN;
        if (addr_ok) push     = 1'b1;
        else         addr_inc = 1'b1;
      end
    end
  end

  // Saturating error counters; clear wins over a same-cycle increment.
  always_comb begin
    sig_err_cnt_d  = sig_err_cnt_q;
    addr_err_cnt_d = addr_err_cnt_q;
    if (clear_err) begin
      sig_err_cnt_d  = '0;
      addr_err_cnt_d = '0;
    end else begin
      if (sig_inc && sig_err_cnt_q != CNT_MAX)
        sig_err_cnt_d = sig_err_cnt_q + CNT_ONE;
      if (addr_inc && addr_err_cnt_q != CNT_MAX)
        addr_err_cnt_d = addr_err_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_RUN;
      sig_err_cnt_q  <= '0;
      addr_err_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      sig_err_cnt_q  <= sig_err_cnt_d;
      addr_err_cnt_q <= addr_err_cnt_d;
    end
  end

  unpacker_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (out_ready),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level),
    .rdata (fifo_head)
  );

endmodule

// File: tb/tb_extended_word_unpacker.sv
// Self-checking bench for extended_word_unpacker: directed scenarios plus
// randomized traffic, all compared against a queue-based reference model.
module tb_extended_word_unpacker;
  import extended_word_unpacker_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] SIG   = 32'h12345678;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] in_data;
  logic [31:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [15:0] out_addr;
  logic [3:0]  level;
  logic [7:0]  sig_err_cnt;
  logic [7:0]  addr_err_cnt;
  logic        resync;
  logic        clear_err;

  extended_word_unpacker dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_addr      (in_addr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_addr     (out_addr),
    .level        (level),
    .sig_err_cnt  (sig_err_cnt),
    .addr_err_cnt (addr_err_cnt),
    .resync       (resync),
    .clear_err    (clear_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  unpack_entry_t m_q[$];
  int            m_sig_cnt;
  int            m_addr_cnt;
  bit            m_drop;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [39:0] good_word(input logic [7:0] p);
    return {p, SIG};
  endfunction

  function automatic logic [31:0] dup(input logic [15:0] a);
    return {a, a};
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_sig_cnt  = 0;
    m_addr_cnt = 0;
    m_drop     = 1'b0;
  endtask

  // Compare all observable outputs against the model (called at negedge).
  task automatic check_state();
    check_eq("in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
    check_eq("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    check_eq("level", 32'(level), 32'(m_q.size()));
    check_eq("sig_err_cnt", 32'(sig_err_cnt), 32'(m_sig_cnt));
    check_eq("addr_err_cnt", 32'(addr_err_cnt), 32'(m_addr_cnt));
    check_eq("resync", 32'(resync), 32'(m_drop));
    if (m_q.size() != 0) begin
      check_eq("out_data", 32'(out_data), 32'(m_q[0].data));
      check_eq("out_addr", 32'(out_addr), 32'(m_q[0].addr));
    end
  endtask

  // One clock: check, drive, advance the model to the next edge, wait.
  task automatic step(input logic v, input logic [39:0] d, input logic [31:0] a,
                      input logic ordy, input logic clr);
    bit            ready_now;
    bit            sig_good;
    bit            addr_good;
    unpack_entry_t e;
    check_state();
    in_valid  = v;
    in_data   = d;
    in_addr   = a;
    out_ready = ordy;
    clear_err = clr;
    ready_now = (m_q.size() != DEPTH);
    sig_good  = (d[31:0] == SIG);
    addr_good = (a[31:16] == a[15:0]);
    if (ordy && m_q.size() != 0) void'(m_q.pop_front());
    if (clr) begin
      m_sig_cnt  = 0;
      m_addr_cnt = 0;
    end
    if (v && ready_now) begin
      if (!sig_good) begin
        if (!m_drop && !clr && m_sig_cnt < 255) m_sig_cnt++;
        m_drop = 1'b1;
      end else begin
        m_drop = 1'b0;
        if (addr_good) begin
          e.data = d[39:32];
          e.addr = a[15:0];
          m_q.push_back(e);
        end else if (!clr && m_addr_cnt < 255) begin
          m_addr_cnt++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, ordy, 1'b0);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_addr   = '0;
    out_ready = 1'b0;
    clear_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [39:0] d;
    logic [31:0] a;
    logic [15:0] lo;
    model_clear();
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; in_addr = '0; out_ready = 1'b0; clear_err = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // Three good words, consumer always ready.
    for (int i = 0; i < 3; i++)
      step(1'b1, good_word(8'(8'hA1 + i)), dup(16'(16'h0010 + i)), 1'b1, 1'b0);
    idle(3, 1'b1);

    // Fill to full with consumer stalled, then a single pop.
    for (int i = 0; i < 8; i++)
      step(1'b1, good_word(8'(8'hB0 + i)), dup(16'(16'h0100 + i)), 1'b0, 1'b0);
    check_eq("full_level", 32'(level), 32'd8);
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check_eq("pop_level", 32'(level), 32'd7);
    check_eq("pop_in_ready", 32'(in_ready), 32'd1);
    idle(8, 1'b1);

    // Signature error burst followed by a clean word.
    step(1'b1, {8'h11, 32'hDEADBEEF}, dup(16'h0200), 1'b1, 1'b0);
    step(1'b1, {8'h22, 32'hDEADBEEF}, dup(16'h0201), 1'b1, 1'b0);
    step(1'b1, {8'h33, 32'h00000000}, dup(16'h0202), 1'b1, 1'b0);
    check_eq("burst_resync", 32'(resync), 32'd1);
    step(1'b1, good_word(8'h55), dup(16'h0203), 1'b1, 1'b0);
    check_eq("burst_sig_cnt", 32'(sig_err_cnt), 32'd1);
    check_eq("burst_out_data", 32'(out_data), 32'h55);
    idle(2, 1'b1);

    // Address halves disagree.
    step(1'b1, good_word(8'h66), {16'h1234, 16'h1235}, 1'b1, 1'b0);
    check_eq("addr_err_cnt1", 32'(addr_err_cnt), 32'd1);
    check_eq("addr_resync", 32'(resync), 32'd0);
    idle(2, 1'b1);

    // Saturation of the signature error counter, then clear vs increment.
    for (int i = 0; i < 256; i++) begin
      step(1'b1, {8'(i), 32'hDEADBEEF}, dup(16'(i)), 1'b1, 1'b0);
      step(1'b1, good_word(8'(i)), dup(16'(i)), 1'b1, 1'b0);
    end
    check_eq("sig_sat", 32'(sig_err_cnt), 32'hFF);
    step(1'b1, {8'h77, 32'hDEADBEEF}, dup(16'h0300), 1'b1, 1'b1);
    check_eq("clear_prio", 32'(sig_err_cnt), 32'd0);
    step(1'b1, good_word(8'h78), dup(16'h0301), 1'b1, 1'b0);
    idle(2, 1'b1);

    // Reset with five entries buffered.
    for (int i = 0; i < 5; i++)
      step(1'b1, good_word(8'(8'hC0 + i)), dup(16'(16'h0400 + i)), 1'b0, 1'b0);
    check_eq("pre_rst_level", 32'(level), 32'd5);
    do_reset();
    check_eq("mid_rst_level", 32'(level), 32'd0);
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("mid_rst_resync", 32'(resync), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      lo = 16'($urandom);
      d  = {8'($urandom), ($urandom_range(0, 9) < 8) ? SIG : 32'($urandom)};
      a  = ($urandom_range(0, 9) < 8) ? {lo, lo} : {16'($urandom), lo};
      step(1'($urandom_range(0, 9) < 7), d, a, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < 2));
    end
    idle(10, 1'b1);
    check_state();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/extended_word_unpacker.md
# extended_word_unpacker

Downstream consumer of the data/address packing stage. Takes the extended word (payload concatenated with a 32-bit signature) and the duplicated full address, checks both for integrity, and buffers good payload/address pairs in a small FIFO. The FIFO drains through a valid/ready stream to the memory-side logic. Bad words are dropped and counted, and a resync state machine discards traffic after a signature error until a clean word arrives.

## Interface
- DATA_WIDTH, 8, payload width
- ADDR_WIDTH, 16, single address width
- FIFO_DEPTH, 8, FIFO entries; power of two, ≥ 2
- SIGNATURE, 32'h12345678, expected low 32 bits of every extended word
- ERR_WIDTH, 8, error counter width
- Derived localparams: EXT_WIDTH = DATA_WIDTH+32, FULL_ADDR_WIDTH = 2*ADDR_WIDTH, PTR_W = log2(FIFO_DEPTH)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  extended word present
- in_ready  out  1  block can accept; = !full
- in_data  in  EXT_WIDTH  {payload, signature}
- in_addr  in  FULL_ADDR_WIDTH  {addr_hi, addr_lo}; the two halves must match
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer takes head entry
- out_data  out  DATA_WIDTH  head payload
- out_addr  out  ADDR_WIDTH  head address
- level  out  PTR_W+1  FIFO occupancy
- sig_err_cnt  out  ERR_WIDTH  signature mismatches, saturating
- addr_err_cnt  out  ERR_WIDTH  address-half mismatches, saturating
- resync  out  1  high while in DROP state
- clear_err  in  1  zero both error counters

## Operation
- An input word is accepted when in_valid && in_ready.
- sig_ok = (in_data[31:0] == SIGNATURE).
- addr_ok = (in_addr[FULL_ADDR_WIDTH-1:ADDR_WIDTH] == in_addr[ADDR_WIDTH-1:0]).
- FSM states RUN and DROP. Reset state is RUN.
  - RUN, accepted word, sig_ok && addr_ok: push {in_data[EXT_WIDTH-1:32], in_addr[ADDR_WIDTH-1:0]} into the FIFO.
  - RUN, accepted word, !sig_ok: drop the word, increment sig_err_cnt, go to DROP.
  - RUN, accepted word, sig_ok && !addr_ok: drop the word, increment addr_err_cnt, stay in RUN.
  - DROP, accepted word, !sig_ok: drop it. No counter increment; consecutive bad signatures count once.
  - DROP, accepted word, sig_ok: go to RUN. The word itself follows the RUN rules, so it is pushed if addr_ok, otherwise counted in addr_err_cnt.
- in_ready stays = !full in DROP as well, so dropped words still drain the upstream stage.
- Pop happens when out_valid && out_ready. out_data/out_addr always show the head entry, and are don't-care when empty.
- Counters saturate at all-ones. clear_err has priority over an increment in the same cycle.
- Reset values: level 0, out_valid 0, in_ready 1, both counters 0, resync 0, read/write pointers 0. FIFO array contents are not reset.

## Timing
- Push-to-out_valid latency is 1 cycle. The FIFO is registered with no fall-through.
- Simultaneous push and pop with 0 < level < FIFO_DEPTH: level is unchanged and both pointers advance.
- Full: in_ready = 0 in the same cycle level reaches FIFO_DEPTH. A pop while full re-raises in_ready on the next cycle. There is no combinational path from out_ready to in_ready.
- Empty with a push: out_valid rises the next cycle. A pop attempt while empty is ignored.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from level.
- resync asserts the cycle after the bad word is accepted.
- Reset mid-burst: all entries discarded and state returns to RUN on the next edge.

## Structure
- Shared package holds the SIGNATURE default, the state enum {RUN, DROP} and a payload/address entry struct.
- One sub-module, unpacker_sync_fifo: parameterised width/depth, with push, pop, full, empty, level and head outputs.
- FSM and checks live in the top module.

## Test plan
- Reset then 3 good words (payload 8'hA1..A3, addr 16'h0010..0012 duplicated), out_ready=1 → out_valid one cycle after each accept; outputs A1/0010, A2/0011, A3/0012 in order; counters 0.
- out_ready=0, push 8 good words → level 8, in_ready 0 on the 8th accept. Then one pop → in_ready 1 the following cycle, level 7.
- Word with signature 32'hDEADBEEF, then 2 more bad, then a good word 8'h55 → sig_err_cnt 1, resync high for 3 cycles, only 8'h55 emerges.
- Good signature with addr {16'h1234, 16'h1235} → dropped, addr_err_cnt 1, FSM stays RUN.
- 256 bad/good alternating pairs with ERR_WIDTH=8 → sig_err_cnt saturates at 8'hFF. clear_err together with a new error → counter 0.
- Reset asserted with level 5 → next cycle level 0, out_valid 0, in_ready 1, resync 0.
